// File: rtl/gnn_pkg.sv
// Shared definitions for the GNN datapath.
// Holds the dense-layer FSM state encoding, the default operand and
// accumulator widths shared with top, and constant helper functions for
// counter sizing and accumulator saturation limits.
package gnn_pkg;

  // Default element and accumulator widths used by top.
  localparam int GNN_DW    = 5;
  localparam int GNN_ACC_W = 21;

  // Dense-layer sequencer states.
  typedef logic [1:0] gnn_state_t;
  localparam gnn_state_t ST_IDLE = 2'd0;
  localparam gnn_state_t ST_ACC  = 2'd1;
  localparam gnn_state_t ST_OUT  = 2'd2;
  localparam gnn_state_t ST_HOLD = 2'd3;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r = r + 32'sd1;
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

  // Largest positive value representable in a signed acc_w-bit word.
  function automatic longint sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 32'sd1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed acc_w-bit word.
  function automatic longint sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 32'sd1));
  endfunction

endpackage

// File: rtl/gnn_mac_lane.sv
// One multiply-accumulate lane of the dense layer.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset, clears acc
//   clr    clears acc and the saturation flag (start of a transaction)
//   en     accumulate a*b into acc this cycle
//   a, b   signed DW-bit operands
//   acc    signed ACC_W-bit running sum
// With SAT_EN=1 an out-of-range sum clamps and the lane then freezes until
// the next clr, so a saturated result cannot drift back into range.
module gnn_mac_lane
  import gnn_pkg::*;
#(
  parameter int DW     = GNN_DW,
  parameter int ACC_W  = GNN_ACC_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  localparam logic signed [ACC_W:0] MAX_S = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_S = (ACC_W+1)'(sat_min(ACC_W));

  logic signed [2*DW-1:0]  prod_s;
  logic signed [ACC_W:0]   sum_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic                    sat_nxt_s;
  logic                    sat_r;

  // Full-precision product and one-bit-wider sum, then clamp or wrap.
  always_comb begin
    prod_s    = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    sum_s     = $signed({acc[ACC_W-1], acc})
              + $signed({{(ACC_W+1-2*DW){prod_s[2*DW-1]}}, prod_s});
    acc_nxt_s = sum_s[ACC_W-1:0];
    sat_nxt_s = 1'b0;
    if (SAT_EN) begin
      if (sum_s > MAX_S) begin
        acc_nxt_s = MAX_S[ACC_W-1:0];
        sat_nxt_s = 1'b1;
      end else if (sum_s < MIN_S) begin
        acc_nxt_s = MIN_S[ACC_W-1:0];
        sat_nxt_s = 1'b1;
      end else begin
        acc_nxt_s = sum_s[ACC_W-1:0];
        sat_nxt_s = 1'b0;
      end
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
      sat_nxt_s = 1'b0;
    end
  end

  // Accumulator and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      sat_r <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      sat_r <= 1'b0;
    end else if (en && !sat_r) begin
      acc   <= acc_nxt_s;
      sat_r <= sat_nxt_s;
    end
  end

endmodule

// File: rtl/gnn_dense_layer_seq.sv
// Time-multiplexed dense layer: y[j] = act(sum_k x[k]*w[k][j]).
// N_OUT MAC lanes run in parallel while the N_IN inputs are walked one per
// cycle from captured operand registers.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid / in_ready  input handshake; x, w captured on acceptance
//   x                    x[k] = x[k*DW +: DW], signed
//   w                    w[k][j] = w[(k*N_OUT+j)*DW +: DW], signed
//   out_valid/out_ready  output handshake; y held until taken
//   y                    y[j] = y[j*ACC_W +: ACC_W], signed
//   busy                 sequencer is not idle
module gnn_dense_layer_seq
  import gnn_pkg::*;
#(
  parameter int DW      = GNN_DW,
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter int ACC_W   = GNN_ACC_W,
  parameter bit RELU_EN = 1'b1,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DW-1:0]       x,
  input  logic [N_IN*N_OUT*DW-1:0] w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*ACC_W-1:0]   y,
  output logic                     busy
);

  localparam int              KW     = clog2(N_IN);
  localparam logic [KW-1:0]   K_LAST = KW'(N_IN - 1);
  localparam logic [KW-1:0]   K_ONE  = KW'(1);

  gnn_state_t                 state_r;
  logic [KW-1:0]              k_r;
  // Operands shift down one element per ACC cycle, so the current x[k] and
  // row w[k][*] always sit in the low bits.
  logic [N_IN*DW-1:0]         x_r;
  logic [N_IN*N_OUT*DW-1:0]   w_r;
  logic [N_OUT*ACC_W-1:0]     acc_all_s;
  logic [N_OUT*ACC_W-1:0]     post_s;
  logic                       clr_s;
  logic                       en_s;

  // Lane controls: clear on acceptance, accumulate while in ACC.
  always_comb begin
    clr_s = 1'b0;
    en_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      clr_s = in_valid;
    end else begin
      clr_s = 1'b0;
    end
    if (state_r == ST_ACC) begin
      en_s = 1'b1;
    end else begin
      en_s = 1'b0;
    end
  end

  genvar j;
  generate
    for (j = 0; j < N_OUT; j++) begin : g_lane
      gnn_mac_lane #(
        .DW     (DW),
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (en_s),
        .a     (x_r[DW-1:0]),
        .b     (w_r[j*DW +: DW]),
        .acc   (acc_all_s[j*ACC_W +: ACC_W])
      );
    end
  endgenerate

  // Output activation: optional ReLU on each lane.
  always_comb begin
    post_s = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (RELU_EN && acc_all_s[i*ACC_W + ACC_W - 1]) begin
        post_s[i*ACC_W +: ACC_W] = '0;
      end else begin
        post_s[i*ACC_W +: ACC_W] = acc_all_s[i*ACC_W +: ACC_W];
      end
    end
  end

  // Sequencer, operand registers, k counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      k_r       <= '0;
      x_r       <= '0;
      w_r       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r      <= x;
            w_r      <= w;
            k_r      <= '0;
            state_r  <= ST_ACC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ACC: begin
          x_r <= x_r >> DW;
          w_r <= w_r >> (N_OUT * DW);
          if (k_r == K_LAST) begin
            k_r     <= '0;
            state_r <= ST_OUT;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        ST_OUT: begin
          y         <= post_s;
          out_valid <= 1'b1;
          state_r   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
